// File: rtl/gated_shift_reg.sv
// Gated shift/rotate/load/increment register with serial in/out and a saturating shift counter.
// Optional registered even-parity output is enabled by defining GATED_SHIFT_REG_PARITY_EN.
module gated_shift_reg #(
   parameter int          WIDTH  = 8,
   parameter logic [19:0] ID_NUM = 20'h65166
) (
   input  logic                       clk,
   input  logic                       clear,
   input  logic                       preset,
   input  logic                       en,
   input  logic [2:0]                 mode,
   input  logic [WIDTH-1:0]           ip0,
   input  logic [WIDTH-1:0]           ip1,
   input  logic                       ser_in,
   output logic [WIDTH-1:0]           op0,
   output logic [WIDTH-1:0]           op0bar,
   output logic                       ser_out,
   output logic                       word_done,
   output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
   output logic [19:0]                id_num
`ifdef GATED_SHIFT_REG_PARITY_EN
   ,
   output logic                       parity
`endif
);

   localparam int CW = $clog2(WIDTH+1);
   localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH);
   localparam logic [CW-1:0]    CNT_ONE = CW'(1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_INC  = 3'b110;

   logic [WIDTH-1:0] op_nxt;
   logic             ser_nxt;
   logic [CW-1:0]    cnt_nxt;
   logic             done_nxt;
   logic             is_shift;

   always_comb begin
      op_nxt   = op0;
      ser_nxt  = ser_out;
      cnt_nxt  = shift_cnt;
      is_shift = 1'b0;
      if (en) begin
         case (mode)
            MODE_LOAD: begin
               op_nxt  = ip0 & ip1;
               cnt_nxt = '0;
            end
            MODE_SHL: begin
               op_nxt   = {op0[WIDTH-2:0], ser_in};
               ser_nxt  = op0[WIDTH-1];
               is_shift = 1'b1;
            end
            MODE_SHR: begin
               op_nxt   = {ser_in, op0[WIDTH-1:1]};
               ser_nxt  = op0[0];
               is_shift = 1'b1;
            end
            MODE_ROL: begin
               op_nxt   = {op0[WIDTH-2:0], op0[WIDTH-1]};
               ser_nxt  = op0[WIDTH-1];
               is_shift = 1'b1;
            end
            MODE_ROR: begin
               op_nxt   = {op0[0], op0[WIDTH-1:1]};
               ser_nxt  = op0[0];
               is_shift = 1'b1;
            end
            MODE_INC: begin
               op_nxt  = op0 + ONE;
               cnt_nxt = '0;
            end
            default: begin
               op_nxt = op0;
            end
         endcase
      end
      if (is_shift && shift_cnt != CNT_MAX) begin
         cnt_nxt = shift_cnt + CNT_ONE;
      end
      // Pulse only on the edge that reaches WIDTH, never while already saturated.
      done_nxt = is_shift && (shift_cnt == CNT_MAX - CNT_ONE);
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         op0       <= '0;
         ser_out   <= 1'b0;
         shift_cnt <= '0;
         word_done <= 1'b0;
      end else if (preset) begin
         op0       <= '1;
         ser_out   <= 1'b0;
         shift_cnt <= '0;
         word_done <= 1'b0;
      end else begin
         op0       <= op_nxt;
         ser_out   <= ser_nxt;
         shift_cnt <= cnt_nxt;
         word_done <= done_nxt;
      end
   end

`ifdef GATED_SHIFT_REG_PARITY_EN
   // Registered alongside op0 so it always describes the current op0 value.
   always_ff @(posedge clk) begin
      if (clear) begin
         parity <= 1'b0;
      end else if (preset) begin
         parity <= ^{WIDTH{1'b1}};
      end else begin
         parity <= ^op_nxt;
      end
   end
`endif

   assign op0bar = ~op0;
   assign id_num = ID_NUM;

   logic unused_mode_hold;
   assign unused_mode_hold = (MODE_HOLD == 3'b000);

endmodule

// File: tb/tb_gated_shift_reg.sv
// Self-checking bench for gated_shift_reg (WIDTH=8): directed cases plus randomized traffic
// compared against an arithmetic reference model.
module tb_gated_shift_reg;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         clear, preset, en, ser_in;
   logic [2:0]   mode;
   logic [W-1:0] ip0, ip1;
   logic [W-1:0] op0, op0bar;
   logic         ser_out, word_done;
   logic [3:0]   shift_cnt;
   logic [19:0]  id_num;
`ifdef GATED_SHIFT_REG_PARITY_EN
   logic         parity;
`endif

   int checks = 0;
   int errors = 0;

   int m_op, m_ser, m_cnt, m_done;

   always #5 clk = ~clk;

   gated_shift_reg #(.WIDTH(W)) dut (
      .clk       (clk),
      .clear     (clear),
      .preset    (preset),
      .en        (en),
      .mode      (mode),
      .ip0       (ip0),
      .ip1       (ip1),
      .ser_in    (ser_in),
      .op0       (op0),
      .op0bar    (op0bar),
      .ser_out   (ser_out),
      .word_done (word_done),
      .shift_cnt (shift_cnt),
      .id_num    (id_num)
`ifdef GATED_SHIFT_REG_PARITY_EN
      ,
      .parity    (parity)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: register value as a number, shifts as multiply/divide by two.
   task automatic model_step();
      int sh;
      sh = 0;
      if (clear) begin
         m_op = 0; m_ser = 0; m_cnt = 0; m_done = 0;
      end else if (preset) begin
         m_op = 255; m_ser = 0; m_cnt = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (en) begin
            case (mode)
               3'd1: begin m_op = int'(ip0 & ip1); m_cnt = 0; end
               3'd2: begin m_ser = m_op / 128; m_op = (m_op * 2) % 256 + int'(ser_in); sh = 1; end
               3'd3: begin m_ser = m_op % 2; m_op = m_op / 2 + 128 * int'(ser_in); sh = 1; end
               3'd4: begin m_ser = m_op / 128; m_op = (m_op * 2) % 256 + m_op / 128; sh = 1; end
               3'd5: begin m_ser = m_op % 2; m_op = m_op / 2 + 128 * (m_op % 2); sh = 1; end
               3'd6: begin m_op = (m_op + 1) % 256; m_cnt = 0; end
               default: ;
            endcase
            if (sh == 1) begin
               if (m_cnt == W - 1) m_done = 1;
               if (m_cnt < W) m_cnt = m_cnt + 1;
            end
         end
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_op0"}, 32'(op0), 32'(m_op));
      chk({tag, "_op0bar"}, 32'(op0bar), 32'(255 - m_op));
      chk({tag, "_ser_out"}, 32'(ser_out), 32'(m_ser));
      chk({tag, "_word_done"}, 32'(word_done), 32'(m_done));
      chk({tag, "_shift_cnt"}, 32'(shift_cnt), 32'(m_cnt));
      chk({tag, "_id_num"}, 32'(id_num), 32'h65166);
`ifdef GATED_SHIFT_REG_PARITY_EN
      chk({tag, "_parity"}, 32'(parity), 32'($countones(m_op[7:0]) % 2));
`endif
   endtask

   task automatic drive(input logic c, input logic p, input logic e, input logic [2:0] m,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      clear = c; preset = p; en = e; mode = m; ip0 = a; ip1 = b; ser_in = s;
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_model(tag);
   endtask

   initial begin
      int done_seen;
      drive(1'b1, 1'b0, 1'b0, 3'd0, '0, '0, 1'b0);
      cyc("clr");
      chk("r025_op0", 32'(op0), 32'h00);
      chk("r025_op0bar", 32'(op0bar), 32'hFF);
      chk("r025_cnt", 32'(shift_cnt), 32'd0);
      chk("r025_done", 32'(word_done), 32'd0);
      drive(1'b0, 1'b1, 1'b1, 3'd1, 8'h12, 8'h34, 1'b1);
      cyc("pre");
      chk("r025_preset", 32'(op0), 32'hFF);

      drive(1'b0, 1'b0, 1'b1, 3'd1, 8'hF0, 8'h3C, 1'b0);
      cyc("ld");
      chk("r026_op0", 32'(op0), 32'h30);
      chk("r026_cnt", 32'(shift_cnt), 32'd0);

      drive(1'b0, 1'b0, 1'b1, 3'd1, 8'h81, 8'hFF, 1'b0);
      cyc("ld81");
      drive(1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 8'h00, 1'b0);
      cyc("shl");
      chk("r027_shl_op0", 32'(op0), 32'h02);
      chk("r027_shl_ser", 32'(ser_out), 32'd1);
      drive(1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 8'h00, 1'b1);
      cyc("ror");
      chk("r027_ror_op0", 32'(op0), 32'h01);
      chk("r027_ror_ser", 32'(ser_out), 32'd0);

      drive(1'b0, 1'b0, 1'b1, 3'd1, 8'hA5, 8'hFF, 1'b0);
      cyc("ldA5");
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 1'b1, 3'd4, 8'h00, 8'h00, 1'b0);
         cyc("rol");
         if (word_done === 1'b1) done_seen++;
      end
      chk("r028_op0", 32'(op0), 32'hA5);
      chk("r028_cnt", 32'(shift_cnt), 32'd8);
      chk("r028_done_now", 32'(word_done), 32'd1);
      chk("r028_done_count", 32'(done_seen), 32'd1);
      cyc("rol9");
      chk("r028_9th_done", 32'(word_done), 32'd0);
      chk("r028_9th_cnt", 32'(shift_cnt), 32'd8);

      drive(1'b0, 1'b0, 1'b1, 3'd1, 8'hFF, 8'hFF, 1'b0);
      cyc("ldFF");
      drive(1'b0, 1'b0, 1'b1, 3'd6, 8'h00, 8'h00, 1'b0);
      cyc("inc");
      chk("r029_wrap", 32'(op0), 32'h00);
      drive(1'b0, 1'b0, 1'b1, 3'd1, 8'h5A, 8'hFF, 1'b0);
      cyc("ld5A");
      drive(1'b1, 1'b1, 1'b1, 3'd1, 8'hFF, 8'hFF, 1'b1);
      cyc("clrpre");
      chk("r029_clr_wins", 32'(op0), 32'h00);

      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 8'h00, 1'b1);
         cyc("shr");
      end
      chk("r030_cnt4", 32'(shift_cnt), 32'd4);
      drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
      cyc("abort");
      chk("r030_cnt_clr", 32'(shift_cnt), 32'd0);
      done_seen = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 8'h00, 1'b1);
         cyc("shr2");
         if (word_done === 1'b1) done_seen++;
      end
      chk("r030_no_done", 32'(done_seen), 32'd0);
      chk("r030_cnt_after", 32'(shift_cnt), 32'd4);
      drive(1'b0, 1'b0, 1'b1, 3'd1, 8'h07, 8'hFF, 1'b0);
      cyc("ld07");
`ifdef GATED_SHIFT_REG_PARITY_EN
      chk("r030_parity", 32'(parity), 32'd1);
`endif

      for (int i = 0; i < 3000; i++) begin
         logic [2:0] m;
         m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 5));
         drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 63) == 0),
               ($urandom_range(0, 3) != 0), m, 8'($urandom), 8'($urandom), 1'($urandom));
         cyc("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
